exe_stage: RTL and testbench
============================

EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 SHALL have port clk, input, 1, rising-edge clock.
REQ-002 SHALL have port resetn, input, 1, reset; synchronous, active-low.
REQ-003 SHALL have port id_to_exe_valid, input, 1, decode bundle valid.
REQ-004 SHALL have port exe_allowin, output, 1, stage can accept a bundle this cycle.
REQ-005 SHALL have port id_pc, input, 32, instruction PC.
REQ-006 SHALL have port id_alu_data_all, input, 76, {alu_op[11:0], alu_src1[31:0], alu_src2[31:0]}.
REQ-007 SHALL have port id_div_op, input, 4, one-hot {mod_wu, div_wu, mod_w, div_w}; 0 means not a divide.
REQ-008 SHALL have ports id_res_from_mem (1), id_mem_we (1), id_rkd_value (32), id_rf_all (6, {rf_we, rf_waddr}), all inputs.
REQ-009 SHALL have port mem_allowin, input, 1, downstream accept.
REQ-010 SHALL have ports exe_valid (1) and exe_to_mem_valid (1), both outputs.
REQ-011 SHALL have port exe_pc, output, 32, registered PC.
REQ-012 SHALL have port exe_fwd_all, output, 39, {res_from_mem, rf_we, rf_waddr, result}.
REQ-013 SHALL have ports data_sram_en (1), data_sram_we (4), data_sram_addr (32), data_sram_wdata (32), all outputs.

Function
REQ-014 Bundle SHALL be captured on the rising edge where id_to_exe_valid & exe_allowin; exe_valid SHALL load id_to_exe_valid whenever exe_allowin.
REQ-015 exe_allowin SHALL equal ~exe_valid | (exe_ready_go & mem_allowin); exe_to_mem_valid SHALL equal exe_valid & exe_ready_go.
REQ-016 Non-divide ops SHALL complete combinationally in the shared alu; exe_ready_go SHALL be 1 and latency 1 cycle.
REQ-017 A divide SHALL use an FSM IDLE -> BUSY -> DONE; IDLE -> BUSY on the first cycle exe_valid & div_op != 0; BUSY SHALL last exactly 32 cycles; BUSY -> DONE after the last iteration; DONE -> IDLE when the bundle leaves (exe_to_mem_valid & mem_allowin).
REQ-018 exe_ready_go SHALL be 0 in IDLE and BUSY for divide bundles, and 1 only in DONE; result SHALL be valid in DONE, 34 cycles after capture.
REQ-019 Signed ops SHALL divide magnitudes and apply signs: quotient negative iff signs differ, remainder takes the dividend sign.
REQ-020 Divide by zero SHALL yield quotient 0xFFFFFFFF and remainder = dividend; 0x80000000 / -1 signed SHALL yield quotient 0x80000000, remainder 0.
REQ-021 result SHALL be the quotient for div_w/div_wu, the remainder for mod_w/mod_wu, and otherwise the alu result.
REQ-022 data_sram_en SHALL assert only in the single cycle the bundle leaves (exe_to_mem_valid & mem_allowin) and only when res_from_mem | mem_we; data_sram_we SHALL be 4'hF for stores and 0 otherwise.
REQ-023 data_sram_addr SHALL be the alu result; data_sram_wdata SHALL be id_rkd_value, registered at capture.
REQ-024 exe_fwd_all rf_we SHALL be gated by exe_valid; a dependant stage SHALL see result only when exe_ready_go, with rf_we forced to 0 while a divide is not DONE.
REQ-025 On simultaneous bundle departure and new capture, the FSM SHALL return to IDLE and the new bundle SHALL start fresh.

Reset
REQ-026 On resetn low, exe_valid SHALL be 0, the FSM SHALL be IDLE, the iteration counter SHALL be 0, and data_sram_en/we SHALL be 0; datapath registers SHALL be don't-care.
REQ-027 Reset mid-divide SHALL abandon the operation; no stale result SHALL be presented after reset.

Structure
REQ-028 ALU op encodings, div_op bit positions, and the bundle widths (76, 39, 6) SHALL live in a shared package.
REQ-029 The iterative restoring divider SHALL be the sub-module div_unit, with ports {start, signed, a, b, busy, done, q, r}.

Verification
REQ-030 Add: src1=5, src2=7, alu_op add -> exe_to_mem_valid next cycle, result=12, data_sram_en=0.
REQ-031 div_w: 0xFFFFFFF9 / 2 -> exe_ready_go=0 for 33 cycles, then quotient 0xFFFFFFFD; mod_w on the same operands gives 0xFFFFFFFF.
REQ-032 div_wu: 7 / 0 -> 0xFFFFFFFF; mod_wu: 7 / 0 -> 7; div_w: 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-033 Store: addr 0x1000, rkd 0xA5A5A5A5, with mem_allowin=0 for 3 cycles -> data_sram_en pulses exactly once, on the cycle mem_allowin rises.
REQ-034 resetn low at BUSY cycle 10 -> exe_valid=0 next edge; a following add completes normally with a correct result.
REQ-035 Back-to-back div then add with mem_allowin=1 -> the add is held in ID until the div departs; ordering is preserved and no bubble follows the departure.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// Shared encodings, bundle widths and the combinational ALU used by the execute stage.
package exe_stage_pkg;

    localparam int ALU_OP_W   = 12;
    localparam int ALU_DATA_W = 76;
    localparam int FWD_W      = 39;
    localparam int RF_ALL_W   = 6;
    localparam int DIV_OP_W   = 4;

    // One-hot bit positions inside alu_op
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    // One-hot bit positions inside div_op
    localparam int DIV_W  = 0;
    localparam int MOD_W  = 1;
    localparam int DIV_WU = 2;
    localparam int MOD_WU = 3;

    typedef struct packed {
        logic        res_from_mem;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] result;
    } fwd_t;

    // src2 already carries the shifted immediate for lui, so lui passes it through.
    function automatic logic [31:0] alu_calc(input logic [ALU_OP_W-1:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        r = '0;
        if (op[ALU_ADD])  r = r | (a + b);
        if (op[ALU_SUB])  r = r | (a - b);
        if (op[ALU_SLT])  r = r | {31'd0, ($signed(a) < $signed(b))};
        if (op[ALU_SLTU]) r = r | {31'd0, (a < b)};
        if (op[ALU_AND])  r = r | (a & b);
        if (op[ALU_NOR])  r = r | ~(a | b);
        if (op[ALU_OR])   r = r | (a | b);
        if (op[ALU_XOR])  r = r | (a ^ b);
        if (op[ALU_SLL])  r = r | (a << b[4:0]);
        if (op[ALU_SRL])  r = r | (a >> b[4:0]);
        if (op[ALU_SRA])  r = r | $unsigned($signed(a) >>> b[4:0]);
        if (op[ALU_LUI])  r = r | b;
        return r;
    endfunction

endpackage

// File: rtl/exe_stage_div.sv
// 32-iteration restoring divider working on magnitudes; signs and the
// divide-by-zero result are applied on the output side.
// done flags the final iteration; q/r are valid from the following cycle until the next start.
module div_unit (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] q,
    output logic [31:0] r
);

    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] dividend_q, dividend_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic        dz_q, dz_d;
    logic [32:0] shifted;
    logic [32:0] trial;

    assign busy = (cnt_q != 6'd0);
    assign done = busy && (cnt_q == 6'd1);

    // Load magnitudes on start, otherwise one shift/subtract step per busy cycle.
    always_comb begin
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        dividend_d = dividend_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        dz_d       = dz_q;
        shifted    = {rem_q, quo_q[31]};
        trial      = shifted - {1'b0, dvs_q};
        if (start) begin
            cnt_d      = 6'd32;
            rem_d      = '0;
            quo_d      = (signed_op && a[31]) ? (~a + 32'd1) : a;
            dvs_d      = (signed_op && b[31]) ? (~b + 32'd1) : b;
            dividend_d = a;
            q_neg_d    = signed_op && (a[31] ^ b[31]);
            r_neg_d    = signed_op && a[31];
            dz_d       = (b == 32'd0);
        end else if (busy) begin
            cnt_d = cnt_q - 6'd1;
            if (!trial[32]) begin
                rem_d = trial[31:0];
                quo_d = {quo_q[30:0], 1'b1};
            end else begin
                rem_d = shifted[31:0];
                quo_d = {quo_q[30:0], 1'b0};
            end
        end
    end

    // Only the iteration count needs a reset; a cleared count abandons any operation.
    always_ff @(posedge clk) begin
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        rem_q      <= rem_d;
        quo_q      <= quo_d;
        dvs_q      <= dvs_d;
        dividend_q <= dividend_d;
        q_neg_q    <= q_neg_d;
        r_neg_q    <= r_neg_d;
        dz_q       <= dz_d;
    end

    assign q = dz_q ? 32'hFFFF_FFFF : (q_neg_q ? (~quo_q + 32'd1) : quo_q);
    assign r = dz_q ? dividend_q    : (r_neg_q ? (~rem_q + 32'd1) : rem_q);

endmodule

// File: rtl/exe_stage.sv
// Execute pipeline stage: single-cycle ALU ops, multi-cycle divides, memory request issue.
//  state | meaning
//  IDLE  | no divide in flight; a divide bundle starts the divider from here
//  BUSY  | divider iterating (32 cycles)
//  DONE  | divide result valid, waiting for the bundle to leave
module exe_stage import exe_stage_pkg::*; (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  id_to_exe_valid,
    output logic                  exe_allowin,
    input  logic [31:0]           id_pc,
    input  logic [ALU_DATA_W-1:0] id_alu_data_all,
    input  logic [DIV_OP_W-1:0]   id_div_op,
    input  logic                  id_res_from_mem,
    input  logic                  id_mem_we,
    input  logic [31:0]           id_rkd_value,
    input  logic [RF_ALL_W-1:0]   id_rf_all,
    input  logic                  mem_allowin,
    output logic                  exe_valid,
    output logic                  exe_to_mem_valid,
    output logic [31:0]           exe_pc,
    output logic [FWD_W-1:0]      exe_fwd_all,
    output logic                  data_sram_en,
    output logic [3:0]            data_sram_we,
    output logic [31:0]           data_sram_addr,
    output logic [31:0]           data_sram_wdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic                  exe_valid_q, exe_valid_d;
    logic [1:0]            state_q, state_d;
    logic [31:0]           pc_q, pc_d;
    logic [ALU_OP_W-1:0]   alu_op_q, alu_op_d;
    logic [31:0]           src1_q, src1_d;
    logic [31:0]           src2_q, src2_d;
    logic [DIV_OP_W-1:0]   div_op_q, div_op_d;
    logic                  res_from_mem_q, res_from_mem_d;
    logic                  mem_we_q, mem_we_d;
    logic [31:0]           rkd_q, rkd_d;
    logic [RF_ALL_W-1:0]   rf_all_q, rf_all_d;

    logic        is_div, exe_ready_go, depart;
    logic        div_start, div_signed, div_busy, div_done;
    logic [31:0] div_q, div_r, alu_result, result;
    fwd_t        fwd;

    assign is_div           = |div_op_q;
    assign exe_ready_go     = !is_div || (state_q == S_DONE);
    assign exe_valid        = exe_valid_q;
    assign exe_allowin      = !exe_valid_q || (exe_ready_go && mem_allowin);
    assign exe_to_mem_valid = exe_valid_q && exe_ready_go;
    assign depart           = exe_to_mem_valid && mem_allowin;
    assign div_start        = exe_valid_q && is_div && (state_q == S_IDLE);
    assign div_signed       = div_op_q[DIV_W] | div_op_q[MOD_W];

    // Pipeline handshake and bundle capture
    always_comb begin
        exe_valid_d    = exe_valid_q;
        pc_d           = pc_q;
        alu_op_d       = alu_op_q;
        src1_d         = src1_q;
        src2_d         = src2_q;
        div_op_d       = div_op_q;
        res_from_mem_d = res_from_mem_q;
        mem_we_d       = mem_we_q;
        rkd_d          = rkd_q;
        rf_all_d       = rf_all_q;
        if (exe_allowin) exe_valid_d = id_to_exe_valid;
        if (id_to_exe_valid && exe_allowin) begin
            pc_d           = id_pc;
            alu_op_d       = id_alu_data_all[75:64];
            src1_d         = id_alu_data_all[63:32];
            src2_d         = id_alu_data_all[31:0];
            div_op_d       = id_div_op;
            res_from_mem_d = id_res_from_mem;
            mem_we_d       = id_mem_we;
            rkd_d          = id_rkd_value;
            rf_all_d       = id_rf_all;
        end
    end

    // Divide sequencing; a departing bundle always returns to IDLE so a
    // bundle captured on the same edge starts fresh.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (div_start)              state_d = S_BUSY;
            S_BUSY: if (div_done || !div_busy)  state_d = S_DONE;
            S_DONE: if (depart)                 state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
    end

    // Control flops with synchronous reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            exe_valid_q <= 1'b0;
            state_q     <= S_IDLE;
        end else begin
            exe_valid_q <= exe_valid_d;
            state_q     <= state_d;
        end
    end

    // Bundle datapath registers, don't-care out of reset
    always_ff @(posedge clk) begin
        pc_q           <= pc_d;
        alu_op_q       <= alu_op_d;
        src1_q         <= src1_d;
        src2_q         <= src2_d;
        div_op_q       <= div_op_d;
        res_from_mem_q <= res_from_mem_d;
        mem_we_q       <= mem_we_d;
        rkd_q          <= rkd_d;
        rf_all_q       <= rf_all_d;
    end

    div_unit u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (div_start),
        .signed_op (div_signed),
        .a         (src1_q),
        .b         (src2_q),
        .busy      (div_busy),
        .done      (div_done),
        .q         (div_q),
        .r         (div_r)
    );

    // Result select and output bundles
    always_comb begin
        alu_result = alu_calc(alu_op_q, src1_q, src2_q);
        if (div_op_q[DIV_W] || div_op_q[DIV_WU])      result = div_q;
        else if (div_op_q[MOD_W] || div_op_q[MOD_WU]) result = div_r;
        else                                          result = alu_result;
        fwd.res_from_mem = res_from_mem_q;
        fwd.rf_we        = rf_all_q[5] && exe_valid_q && exe_ready_go;
        fwd.rf_waddr     = rf_all_q[4:0];
        fwd.result       = result;
    end

    assign exe_pc          = pc_q;
    assign exe_fwd_all     = fwd;
    assign data_sram_en    = depart && (res_from_mem_q || mem_we_q);
    assign data_sram_we    = {4{data_sram_en && mem_we_q}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = rkd_q;

endmodule

// File: tb/tb_exe_stage.sv
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic        clk;
    logic        resetn;
    logic        id_to_exe_valid;
    logic        exe_allowin;
    logic [31:0] id_pc;
    logic [75:0] id_alu_data_all;
    logic [3:0]  id_div_op;
    logic        id_res_from_mem;
    logic        id_mem_we;
    logic [31:0] id_rkd_value;
    logic [5:0]  id_rf_all;
    logic        mem_allowin;
    logic        exe_valid;
    logic        exe_to_mem_valid;
    logic [31:0] exe_pc;
    logic [38:0] exe_fwd_all;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;

    int compared = 0;
    int mismatched = 0;

    exe_stage dut (
        .clk              (clk),
        .resetn           (resetn),
        .id_to_exe_valid  (id_to_exe_valid),
        .exe_allowin      (exe_allowin),
        .id_pc            (id_pc),
        .id_alu_data_all  (id_alu_data_all),
        .id_div_op        (id_div_op),
        .id_res_from_mem  (id_res_from_mem),
        .id_mem_we        (id_mem_we),
        .id_rkd_value     (id_rkd_value),
        .id_rf_all        (id_rf_all),
        .mem_allowin      (mem_allowin),
        .exe_valid        (exe_valid),
        .exe_to_mem_valid (exe_to_mem_valid),
        .exe_pc           (exe_pc),
        .exe_fwd_all      (exe_fwd_all),
        .data_sram_en     (data_sram_en),
        .data_sram_we     (data_sram_we),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result from the architectural definition of each operation.
    function automatic logic [31:0] model(input logic [11:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] dop);
        logic signed [31:0] sa, sb;
        logic [31:0] q, r;
        sa = a;
        sb = b;
        if (dop != 4'd0) begin
            if (b == 32'd0) begin
                q = 32'hFFFF_FFFF;
                r = a;
            end else if (dop[DIV_W] || dop[MOD_W]) begin
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    q = 32'h8000_0000;
                    r = 32'd0;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                end
            end else begin
                q = a / b;
                r = a % b;
            end
            return (dop[DIV_W] || dop[DIV_WU]) ? q : r;
        end
        case (1'b1)
            op[ALU_ADD]:  return a + b;
            op[ALU_SUB]:  return a - b;
            op[ALU_SLT]:  return (sa < sb) ? 32'd1 : 32'd0;
            op[ALU_SLTU]: return (a < b) ? 32'd1 : 32'd0;
            op[ALU_AND]:  return a & b;
            op[ALU_NOR]:  return ~(a | b);
            op[ALU_OR]:   return a | b;
            op[ALU_XOR]:  return a ^ b;
            op[ALU_SLL]:  return a << b[4:0];
            op[ALU_SRL]:  return a >> b[4:0];
            op[ALU_SRA]:  return $unsigned(sa >>> b[4:0]);
            op[ALU_LUI]:  return b;
            default:      return 32'd0;
        endcase
    endfunction

    task automatic drive(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] dop, input logic rfm, input logic mwe,
                         input logic [31:0] rkd, input logic [5:0] rfa, input logic [31:0] pc);
        id_alu_data_all = {op, a, b};
        id_div_op       = dop;
        id_res_from_mem = rfm;
        id_mem_we       = mwe;
        id_rkd_value    = rkd;
        id_rf_all       = rfa;
        id_pc           = pc;
        id_to_exe_valid = 1'b1;
    endtask

    // Issue one bundle with mem_allowin high and check its passage through the stage.
    task automatic send(input string tag, input logic [11:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] dop, input logic rfm,
                        input logic mwe, input logic [31:0] rkd, input logic [5:0] rfa,
                        input logic [31:0] pc);
        int n, lat, fwd_bad, exp_lat;
        logic [31:0] exp;
        exp     = model(op, a, b, dop);
        exp_lat = (dop != 4'd0) ? 34 : 1;
        drive(op, a, b, dop, rfm, mwe, rkd, rfa, pc);
        n = 0;
        while (!exe_allowin && n < 200) begin step(); n++; end
        check({tag, "_allowin"}, 64'(exe_allowin), 64'd1);
        step();
        id_to_exe_valid = 1'b0;
        lat = 1;
        fwd_bad = 0;
        while (!exe_to_mem_valid && lat < 200) begin
            if (exe_fwd_all[37] || data_sram_en) fwd_bad++;
            step();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_result"}, 64'(exe_fwd_all[31:0]), 64'(exp));
        check({tag, "_pc"}, 64'(exe_pc), 64'(pc));
        check({tag, "_fwd_we"}, 64'({exe_fwd_all[38:32]}), 64'({rfm, rfa}));
        check({tag, "_early_fwd"}, 64'(fwd_bad), 64'd0);
        check({tag, "_sram_en"}, 64'({data_sram_en, data_sram_we}),
              64'({rfm | mwe, {4{mwe}}}));
        step();
    endtask

    initial begin
        int pulses, n, held, k;
        logic [11:0] op;
        logic [3:0]  dop;
        logic [31:0] a, b;
        logic [11:0] op_add;
        op_add = 12'd1 << ALU_ADD;

        resetn = 1'b0;
        id_to_exe_valid = 1'b0;
        id_pc = '0;
        id_alu_data_all = '0;
        id_div_op = '0;
        id_res_from_mem = 1'b0;
        id_mem_we = 1'b0;
        id_rkd_value = '0;
        id_rf_all = '0;
        mem_allowin = 1'b1;
        step(); step();
        check("reset_valid", 64'({exe_valid, exe_to_mem_valid}), 64'd0);
        check("reset_sram", 64'({data_sram_en, data_sram_we}), 64'd0);
        check("reset_allowin", 64'(exe_allowin), 64'd1);
        resetn = 1'b1;
        step();

        // Directed operations
        send("add", op_add, 32'd5, 32'd7, 4'd0, 1'b0, 1'b0, 32'd0, 6'h21, 32'h1c00_0000);
        send("div_w", op_add, 32'hFFFF_FFF9, 32'd2, 4'd1 << DIV_W, 1'b0, 1'b0, 32'd0, 6'h22, 32'h1c00_0004);
        send("mod_w", op_add, 32'hFFFF_FFF9, 32'd2, 4'd1 << MOD_W, 1'b0, 1'b0, 32'd0, 6'h23, 32'h1c00_0008);
        send("div_wu_z", op_add, 32'd7, 32'd0, 4'd1 << DIV_WU, 1'b0, 1'b0, 32'd0, 6'h24, 32'h1c00_000c);
        send("mod_wu_z", op_add, 32'd7, 32'd0, 4'd1 << MOD_WU, 1'b0, 1'b0, 32'd0, 6'h25, 32'h1c00_0010);
        send("div_w_ovf", op_add, 32'h8000_0000, 32'hFFFF_FFFF, 4'd1 << DIV_W, 1'b0, 1'b0, 32'd0, 6'h26, 32'h1c00_0014);
        send("mod_w_neg_z", op_add, 32'hFFFF_FFF0, 32'd0, 4'd1 << MOD_W, 1'b0, 1'b0, 32'd0, 6'h27, 32'h1c00_0018);
        send("load", op_add, 32'h2000, 32'h8, 4'd0, 1'b1, 1'b0, 32'd0, 6'h28, 32'h1c00_001c);

        // Store held by downstream back-pressure
        mem_allowin = 1'b0;
        drive(op_add, 32'h1000, 32'd0, 4'd0, 1'b0, 1'b1, 32'hA5A5_A5A5, 6'd0, 32'h1c00_0020);
        step();
        id_to_exe_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            if (data_sram_en) pulses++;
            step();
        end
        check("store_blocked_allowin", 64'(exe_allowin), 64'd0);
        mem_allowin = 1'b1;
        #1;
        if (data_sram_en) pulses++;
        check("store_en", 64'({data_sram_en, data_sram_we}), 64'h1F);
        check("store_addr", 64'(data_sram_addr), 64'h1000);
        check("store_wdata", 64'(data_sram_wdata), 64'hA5A5_A5A5);
        step();
        for (int i = 0; i < 3; i++) begin
            if (data_sram_en) pulses++;
            step();
        end
        check("store_pulses", 64'(pulses), 64'd1);

        // Reset during BUSY cycle 10
        drive(op_add, 32'd1000, 32'd3, 4'd1 << DIV_W, 1'b0, 1'b0, 32'd0, 6'h2a, 32'h1c00_0030);
        step();
        id_to_exe_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        resetn = 1'b0;
        step();
        check("rst_mid_valid", 64'({exe_valid, exe_to_mem_valid, exe_fwd_all[37]}), 64'd0);
        check("rst_mid_sram", 64'({data_sram_en, data_sram_we}), 64'd0);
        resetn = 1'b1;
        step();
        send("post_rst_add", op_add, 32'h7FFF_FFFF, 32'd1, 4'd0, 1'b0, 1'b0, 32'd0, 6'h2b, 32'h1c00_0034);
        send("post_rst_div", op_add, 32'd100, 32'd7, 4'd1 << DIV_WU, 1'b0, 1'b0, 32'd0, 6'h2c, 32'h1c00_0038);

        // Divide followed immediately by an add
        drive(op_add, 32'd100, 32'd7, 4'd1 << DIV_W, 1'b0, 1'b0, 32'd0, 6'h31, 32'h1c00_0040);
        step();
        drive(op_add, 32'd40, 32'd2, 4'd0, 1'b0, 1'b0, 32'd0, 6'h32, 32'h1c00_0044);
        held = 0;
        n = 1;
        while (!exe_to_mem_valid && n < 200) begin
            if (exe_allowin || exe_pc != 32'h1c00_0040) held++;
            step();
            n++;
        end
        check("b2b_hold", 64'(held), 64'd0);
        check("b2b_div_lat", 64'(n), 64'd34);
        check("b2b_div_out", 64'({exe_allowin, exe_pc, exe_fwd_all[31:0]}),
              64'({1'b1, 32'h1c00_0040, 32'd14}));
        step();
        id_to_exe_valid = 1'b0;
        check("b2b_add_out", 64'({exe_to_mem_valid, exe_pc, exe_fwd_all[31:0]}),
              64'({1'b1, 32'h1c00_0044, 32'd42}));
        step();
        check("b2b_drained", 64'(exe_valid), 64'd0);

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            k = $urandom_range(0, 15);
            if (k < 12) begin
                op  = 12'd1 << k;
                dop = 4'd0;
            end else begin
                op  = op_add;
                dop = 4'd1 << (k - 12);
            end
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 20));
                2: b = -32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            send("rand", op, a, b, dop, 1'($urandom_range(0, 1)), 1'b0, $urandom,
                 6'($urandom_range(0, 63)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
